// File: rtl/adsb_pkg.sv
// Shared constants, types and helpers for the ADS-B CRC framer.
package adsb_pkg;
  localparam logic [23:0] CRC24_POLY = 24'hFFF409;
  localparam int          MSG_BITS   = 112;
  localparam int          OUT_BEATS  = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_SEND} state_t;
  typedef logic [1:0] beat_idx_t;

  // One serial CRC-24 step, message bit fed MSB first.
  function automatic logic [23:0] crc24_step(input logic [23:0] crc, input logic b);
    return {crc[22:0], 1'b0} ^ ((crc[23] ^ b) ? CRC24_POLY : 24'h0);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/crc24_serial.sv
// Serial CRC-24 remainder register, one message bit per enabled cycle.
module crc24_serial
  import adsb_pkg::*;
(
  input  logic        clk,
  input  logic        aresetn,
  input  logic        clear,
  input  logic        shift_en,
  input  logic        bit_in,
  output logic [23:0] crc
);
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)      crc <= '0;
    else if (clear)    crc <= '0;
    else if (shift_en) crc <= crc24_step(crc, bit_in);
  end
endmodule

// File: rtl/adsb_crc_framer.sv
// Checks the CRC-24 of each incoming squitter, counts good/bad/dropped
// squitters and re-emits accepted ones as a 4-beat 32-bit AXI-Stream packet.
module adsb_crc_framer
  import adsb_pkg::*;
#(
  parameter int SQUITTER_LENGTH = 128,
  parameter int MSG_BITS        = 112,
  parameter bit FORWARD_BAD     = 1'b0
) (
  input  logic                         s00_axis_aclk,
  input  logic                         s00_axis_aresetn,
  input  logic                         s00_axis_tvalid,
  input  logic                         s00_axis_tlast,
  input  logic [SQUITTER_LENGTH-1:0]   s00_axis_tdata,
  input  logic [SQUITTER_LENGTH/8-1:0] s00_axis_tstrb,
  output logic                         s00_axis_tready,
  output logic                         m00_axis_tvalid,
  input  logic                         m00_axis_tready,
  output logic [31:0]                  m00_axis_tdata,
  output logic                         m00_axis_tlast,
  output logic [3:0]                   m00_axis_tstrb,
  output logic [31:0]                  good_count,
  output logic [31:0]                  bad_count,
  output logic [31:0]                  drop_count
);
  state_t              state;
  logic [MSG_BITS-1:0] msg;
  logic [MSG_BITS-1:0] msg_rot;
  logic [6:0]          bit_cnt;
  beat_idx_t           beat;
  logic                crc_ok;
  logic [23:0]         crc;
  logic                accept, shift_en, last_bit, chk_pass, drop;
  logic                unused_ok;

  assign unused_ok = ^{s00_axis_tlast, s00_axis_tstrb, s00_axis_tdata[SQUITTER_LENGTH-1:MSG_BITS]};

  assign s00_axis_tready = s00_axis_aresetn && (state == ST_IDLE);
  assign accept          = (state == ST_IDLE) && s00_axis_tvalid;
  assign shift_en        = (state == ST_CHECK);
  assign last_bit        = shift_en && (bit_cnt == 7'(MSG_BITS-1));
  assign drop            = s00_axis_tvalid && !s00_axis_tready;
  assign m00_axis_tstrb  = {4{m00_axis_tvalid}};

  // The message rotates through bit MSG_BITS-1 during CHECK; after a full
  // pass it is back in its original order, ready to be sliced into beats.
  assign msg_rot  = {msg[MSG_BITS-2:0], msg[MSG_BITS-1]};
  assign chk_pass = (crc24_step(crc, msg[MSG_BITS-1]) == 24'h0);

  crc24_serial u_crc (
    .clk      (s00_axis_aclk),
    .aresetn  (s00_axis_aresetn),
    .clear    (accept),
    .shift_en (shift_en),
    .bit_in   (msg[MSG_BITS-1]),
    .crc      (crc)
  );

  function automatic logic [31:0] beat_word(input logic [MSG_BITS-1:0] m,
                                            input beat_idx_t b, input logic ok);
    case (b)
      2'd0:    return m[MSG_BITS-1  -: 32];
      2'd1:    return m[MSG_BITS-33 -: 32];
      2'd2:    return m[MSG_BITS-65 -: 32];
      default: return {m[15:0], 15'h0, ok};
    endcase
  endfunction

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state           <= ST_IDLE;
      msg             <= '0;
      bit_cnt         <= '0;
      beat            <= '0;
      crc_ok          <= 1'b0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tdata  <= '0;
      good_count      <= '0;
      bad_count       <= '0;
      drop_count      <= '0;
    end else begin
      if (drop) drop_count <= sat_inc(drop_count);
      case (state)
        ST_IDLE: begin
          if (s00_axis_tvalid) begin
            msg     <= s00_axis_tdata[MSG_BITS-1:0];
            bit_cnt <= '0;
            state   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          msg     <= msg_rot;
          bit_cnt <= bit_cnt + 7'd1;
          if (last_bit) begin
            crc_ok <= chk_pass;
            if (chk_pass) good_count <= sat_inc(good_count);
            else          bad_count  <= sat_inc(bad_count);
            if (chk_pass || FORWARD_BAD) begin
              state           <= ST_SEND;
              beat            <= '0;
              m00_axis_tvalid <= 1'b1;
              m00_axis_tlast  <= 1'b0;
              m00_axis_tdata  <= beat_word(msg_rot, 2'd0, chk_pass);
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_SEND: begin
          if (m00_axis_tready) begin
            if (beat == beat_idx_t'(OUT_BEATS-1)) begin
              state           <= ST_IDLE;
              m00_axis_tvalid <= 1'b0;
              m00_axis_tlast  <= 1'b0;
              m00_axis_tdata  <= '0;
            end else begin
              beat           <= beat + 2'd1;
              m00_axis_tdata <= beat_word(msg, beat + 2'd1, crc_ok);
              m00_axis_tlast <= (beat + 2'd1 == beat_idx_t'(OUT_BEATS-1));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/adsb_crc_framer.md
# adsb_crc_framer

Sits directly downstream of the BPSK squitter decoder and consumes its 128-bit squitter stream. For each squitter it:
- checks the ADS-B CRC-24 with a serial LFSR;
- updates good/bad/drop counters;
- re-emits accepted squitters as a 4-beat, 32-bit AXI-Stream packet for the DMA FIFO, honouring downstream backpressure.

## Interface
Parameters:
- SQUITTER_LENGTH, 128: input tdata width; message occupies [111:0], [127:112] ignored
- MSG_BITS, 112: ADS-B long squitter length in bits
- FORWARD_BAD, 0: 1 = also forward CRC-failed squitters; 0 = discard them

Ports (one clock; reset is asynchronous and active-low):
- s00_axis_aclk  in  1  sole clock
- s00_axis_aresetn  in  1  asynchronous active-low reset
- s00_axis_tvalid  in  1  squitter valid (upstream ignores tready)
- s00_axis_tlast  in  1  ignored
- s00_axis_tdata  in  SQUITTER_LENGTH  squitter; bit 111 = first transmitted bit
- s00_axis_tstrb  in  SQUITTER_LENGTH/8  ignored
- s00_axis_tready  out  1  high only in IDLE
- m00_axis_tvalid  out  1  output beat valid
- m00_axis_tready  in  1  downstream ready
- m00_axis_tdata  out  32  output beat
- m00_axis_tlast  out  1  high on beat 3
- m00_axis_tstrb  out  4  constant 4'hF while tvalid, else 0
- good_count, bad_count, drop_count  out  32 each  saturating event counters

## Operation
- States: IDLE, CHECK, SEND.
- **IDLE**
  - On tvalid: latch tdata[111:0] into the message register, clear the CRC register and the bit counter, go to CHECK.
- **CHECK**, one bit per cycle, MSB first, 112 cycles:
  - fb = crc[23] ^ bit
  - crc = {crc[22:0],0} ^ (fb ? 24'hFFF409 : 0)
  - After bit 0, crc_ok = (crc == 0).
  - crc_ok: good_count++, go to SEND.
  - Not crc_ok: bad_count++, then go to SEND if FORWARD_BAD=1, else go to IDLE.
- **SEND**, four beats:
  - beat0 = msg[111:80]
  - beat1 = msg[79:48]
  - beat2 = msg[47:16]
  - beat3 = {msg[15:0], 15'b0, crc_ok}, with tlast
  - Advance the beat only on tvalid&&tready.
  - After beat 3 handshakes, go to IDLE.
- **Drops:** every cycle with s00_axis_tvalid && !s00_axis_tready increments drop_count. Those squitters are lost.
- **Counters:** all saturate at 32'hFFFF_FFFF.
- **Simultaneous events:**
  - Beat-3 handshake and input tvalid in the same cycle: the squitter counts as a drop, because tready is still low that cycle.
  - Bad-CRC increment and a drop in the same cycle: both counters update independently.

## Timing
- **Reset** (aresetn low, asynchronous), then held until release:
  - state = IDLE
  - s00_axis_tready = 0 while reset is asserted, 1 after release
  - m00_axis_tvalid, tlast, tdata, tstrb = 0
  - all counters = 0
- **Latency:** input accepted at cycle T. CHECK occupies T+1..T+112. Counter update and the first m00_axis_tvalid occur at T+113 (registered).
- **Minimum accept-to-accept period:** 117 cycles, with no backpressure.
- **Output handshake:**
  - tdata, tlast and tvalid stay stable while tvalid && !tready.
  - tvalid is never deasserted before the handshake.
  - With tready held high, the four beats occupy consecutive cycles.
- **Reset mid-CHECK or mid-SEND:** the packet is abandoned and no partial tlast is emitted. After release, the next squitter is accepted normally.
- **s00_axis_tready** = (state==IDLE), combinational from state, gated by reset.

## Structure
- **Package adsb_pkg** holds:
  - CRC24_POLY = 24'hFFF409
  - MSG_BITS = 112
  - OUT_BEATS = 4
  - the state enum typedef
  - the beat-index typedef (2 bits)
- **Sub-module crc24_serial:**
  - inputs clk/aresetn, clear, shift_en, bit_in
  - outputs the 24-bit remainder
  - the framer instantiates it once
- The framer owns the FSM, message shift register, bit counter (7 bits), beat counter and the saturating counters.

## Test plan
1. Valid squitter 0x8D4840D6202CC371C32CE0576098 in tdata[111:0], tready=1 -> at T+113 good_count=1; beats 0x8D4840D6, 0x202CC371, 0xC32CE057, 0x60980001 on consecutive cycles; tlast on beat 3 only.
2. Same squitter with bit 50 flipped, FORWARD_BAD=0 -> bad_count=1, no m00_axis_tvalid, back in IDLE at T+113. With FORWARD_BAD=1 -> four beats, beat3 LSB=0.
3. Second squitter pulsed at T+5 and T+60 during CHECK -> drop_count=2; the first squitter's output is unaffected.
4. m00_axis_tready low for 10 cycles on beat 1 -> beat 1 data held stable with tvalid high; all four beats eventually delivered in order, none duplicated.
5. aresetn pulsed low at T+50 (CHECK) and again during SEND beat 2 -> all outputs and counters 0, no tlast emitted; a subsequent valid squitter produces good_count=1.
6. Preload drop_count to 32'hFFFF_FFFE via forced drops, then 3 more drops -> saturates at 32'hFFFF_FFFF.
